bcd_to_bin_loader: RTL and testbench
====================================

// Module: bcd_to_bin_loader
// PURPOSE
//  Sequential BCD-to-binary converter (reverse double-dabble) for ALU operand entry.
//  Takes NDIGITS packed BCD digits from switches/keypad and returns a DWIDTH-bit binary
//  operand for din1/din2, with ready/valid handshakes on both sides.
//  Flags invalid digits (>9) and values that do not fit in DWIDTH bits.
// PARAMETERS
//  DWIDTH   8  binary output width; must match the ALU operand width
//  NDIGITS  3  number of BCD digits accepted; internal binary width BW = 4*NDIGITS
// PORTS
//  clk        in   1           single clock; all state changes on posedge
//  rst_n      in   1           asynchronous active-low reset
//  bcd_in     in   4*NDIGITS   packed BCD, digit 0 (ones) in [3:0]
//  in_valid   in   1           bcd_in is valid
//  in_ready   out  1           converter can accept; high only in IDLE
//  dout       out  DWIDTH      converted binary operand
//  out_valid  out  1           dout/err_digit/err_ovf are valid
//  out_ready  in   1           consumer accepts result
//  err_digit  out  1           at least one input digit was > 9
//  err_ovf    out  1           value > 2^DWIDTH-1
//  busy       out  1           high in SHIFT
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, dout=0, out_valid=0, err_digit=0, err_ovf=0,
//   busy=0, shift count=0. in_ready=1 immediately after reset is released.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready: latch bcd_in into BCD reg, clear BW-bit
//   binary reg, cnt=0. If any digit >9 -> DONE with dout=0, err_digit=1, err_ovf=0.
//   Otherwise -> SHIFT.
//  SHIFT: one step per cycle, 4*NDIGITS steps (cnt 0..4*NDIGITS-1):
//   {bcd,bin} shifted right by 1 (BCD LSB enters binary MSB), then every BCD digit
//   >=8 is reduced by 3. After the last step -> DONE.
//  DONE entry (registered): out_valid=1; err_ovf=(bin > 2^DWIDTH-1); dout per
//   CONFIGURATION. Outputs are held stable until out_valid&&out_ready, then -> IDLE
//   and out_valid=0 on the next edge. Errors hold their value until the next accept.
//  Latency: accept edge to out_valid high = 4*NDIGITS+1 cycles (13 with NDIGITS=3).
//   The invalid-digit path gives 1 cycle.
//  Throughput: a new input can be accepted on the cycle after out handshake (IDLE).
//  in_valid outside IDLE is ignored; the input is not queued and in_ready stays 0.
//  out_ready while out_valid=0 has no effect.
//  rst_n asserted mid-conversion aborts immediately to reset values; no partial result.
//  Arithmetic: unsigned only. bin is BW bits wide, so no internal overflow is possible.
// CONFIGURATION
//  BCD2BIN_SAT_EN defined: on err_ovf, dout = {DWIDTH{1'b1}} (saturate).
//  BCD2BIN_SAT_EN undefined: on err_ovf, dout = bin[DWIDTH-1:0] (modulo 2^DWIDTH).
//  err_ovf is reported in both builds.
// TESTING
//  1) bcd_in=12'h255, out_ready=1 -> dout=8'hFF after 13 cycles, err_ovf=0, err_digit=0.
//  2) bcd_in=12'h999 -> err_ovf=1; dout=8'd231 without SAT_EN, dout=8'd255 with SAT_EN.
//  3) bcd_in=12'h1A0 -> out_valid after 1 cycle, err_digit=1, dout=0.
//  4) bcd_in=12'h000 then 12'h001 back-to-back -> dout=0, then dout=1.
//     in_ready=0 while busy; no input is lost.
//  5) Hold out_ready=0 for 5 cycles after 12'h128 -> dout=8'd128 stable and
//     out_valid=1 throughout; new in_valid is ignored.
//  6) Pulse rst_n=0 at step 6 of 12'h042 -> outputs return to reset values at once;
//     the next request 12'h042 gives dout=8'd42.

Source files
------------

// File: rtl/bcd_to_bin_loader.sv
// Sequential BCD-to-binary converter (reverse double-dabble) with ready/valid on both sides.
// Optional build macro BCD2BIN_SAT_EN: saturate dout to all-ones on overflow instead of wrapping.
module bcd_to_bin_loader #(
  parameter int DWIDTH  = 8,
  parameter int NDIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DWIDTH-1:0]      dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   err_digit,
  output logic                   err_ovf,
  output logic                   busy
);

  localparam int BW = 4 * NDIGITS;
  localparam int CW = $clog2(BW + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     bin_q, bin_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              bad_q, bad_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              out_valid_q, out_valid_d;
  logic              err_digit_q, err_digit_d;
  logic              err_ovf_q, err_ovf_d;

  logic              in_bad;
  logic [2*BW-1:0]   shifted;
  logic [BW-1:0]     bcd_adj;
  logic              bin_ovf;
  logic [DWIDTH-1:0] bin_trunc;
  logic [DWIDTH-1:0] bin_result;

  // Datapath helpers: digit check, one reverse double-dabble step, range check.
  always_comb begin
    in_bad = 1'b0;
    for (int d = 0; d < NDIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) in_bad = 1'b1;
    end

    shifted = {bcd_q, bin_q} >> 1;
    bcd_adj = shifted[2*BW-1:BW];
    for (int d = 0; d < NDIGITS; d++) begin
      if (shifted[BW + 4*d +: 4] >= 4'd8) bcd_adj[4*d +: 4] = shifted[BW + 4*d +: 4] - 4'd3;
    end

    bin_ovf   = 1'b0;
    for (int i = DWIDTH; i < BW; i++) bin_ovf = bin_ovf | bin_q[i];
    bin_trunc = '0;
    for (int i = 0; i < DWIDTH && i < BW; i++) bin_trunc[i] = bin_q[i];

`ifdef BCD2BIN_SAT_EN
    bin_result = bin_ovf ? {DWIDTH{1'b1}} : bin_trunc;
`else
    bin_result = bin_trunc;
`endif
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latch).
    state_d     = state_q;
    bcd_d       = bcd_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    err_digit_d = err_digit_q;
    err_ovf_d   = err_ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bcd_d       = bcd_in;
          bin_d       = '0;
          cnt_d       = '0;
          bad_d       = in_bad;
          err_digit_d = 1'b0;
          err_ovf_d   = 1'b0;
          state_d     = in_bad ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = shifted[BW-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(BW - 1)) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle registers the result; it then holds until the consumer takes it.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          err_digit_d = bad_q;
          err_ovf_d   = !bad_q && bin_ovf;
          dout_d      = bad_q ? '0 : bin_result;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      err_digit_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      err_digit_q <= err_digit_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign err_digit = err_digit_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_bcd_to_bin_loader.sv
// Scoreboard bench for bcd_to_bin_loader: directed cases plus random BCD operands
// checked against a decimal-arithmetic reference model.
module tb_bcd_to_bin_loader;

  logic        clk;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  dout;
  logic        out_valid;
  logic        out_ready;
  logic        err_digit;
  logic        err_ovf;
  logic        busy;

  bcd_to_bin_loader #(.DWIDTH(8), .NDIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .in_valid(in_valid), .in_ready(in_ready),
    .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
    .err_digit(err_digit), .err_ovf(err_ovf), .busy(busy)
  );

  typedef struct {
    logic [7:0] dout;
    logic       ed;
    logic       eo;
    int         acc;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  bit         rand_en  = 0;
  bit         first_seen = 0;
  bit         prev_valid = 0;
  bit         prev_hs    = 0;
  logic [7:0] prev_dout  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: decimal value of the digits, then range/validity rules.
  function automatic exp_t model(input logic [11:0] v, input int acc);
    exp_t e;
    int   d0, d1, d2, val;
    d0 = int'(v[3:0]);
    d1 = int'(v[7:4]);
    d2 = int'(v[11:8]);
    val = d2 * 100 + d1 * 10 + d0;
    e.acc = acc;
    e.ed  = (d0 > 9) || (d1 > 9) || (d2 > 9);
    e.eo  = !e.ed && (val > 255);
    e.lat = e.ed ? 1 : 13;
    if (e.ed) e.dout = 8'd0;
`ifdef BCD2BIN_SAT_EN
    else if (e.eo) e.dout = 8'd255;
`endif
    else e.dout = 8'(val % 256);
    return e;
  endfunction

  // Monitor: accept observer pushes expectations; output side pops and compares.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
      prev_hs    = 0;
      first_seen = 0;
    end else begin
      if (busy || out_valid) check("in_ready_low", {31'd0, in_ready}, 32'd0);
      if (prev_valid && !prev_hs) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_dout", {24'd0, dout}, {24'd0, prev_dout});
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd0, 32'd1);
        end else begin
          if (!first_seen) begin
            check("latency", cyc - sb[0].acc, sb[0].lat);
            first_seen = 1;
          end
          if (out_ready) begin
            check("dout", {24'd0, dout}, {24'd0, sb[0].dout});
            check("err_digit", {31'd0, err_digit}, {31'd0, sb[0].ed});
            check("err_ovf", {31'd0, err_ovf}, {31'd0, sb[0].eo});
            void'(sb.pop_front());
            first_seen = 0;
          end
        end
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_dout  = dout;
      if (in_valid && in_ready) sb.push_back(model(bcd_in, cyc + 1));
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_en) out_ready = 1'($urandom % 2);
  end

  task automatic send(input logic [11:0] v);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    bcd_in   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 32'd0);
  endtask

  function automatic logic [11:0] rand_bcd();
    logic [11:0] v;
    for (int d = 0; d < 3; d++) begin
      if ($urandom_range(0, 7) == 0) v[4*d +: 4] = 4'($urandom_range(10, 15));
      else v[4*d +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    bcd_in    = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_digit", {31'd0, err_digit}, 32'd0);
    check("rst_err_ovf", {31'd0, err_ovf}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(12'h255);
    send(12'h999);
    send(12'h1A0);
    send(12'h000);
    send(12'h001);
    drain();

    // Consumer stalls; a competing request must be ignored.
    out_ready = 1'b0;
    send(12'h128);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    bcd_in   = 12'h077;
    repeat (5) @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Abort mid-conversion.
    send(12'h042);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_dout", {24'd0, dout}, 32'd0);
    check("abort_err_digit", {31'd0, err_digit}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send(12'h042);
    drain();

    rand_en = 1;
    for (int i = 0; i < 40; i++) send(rand_bcd());
    drain();
    rand_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
